// File: rtl/prog_mem_dump_fsm.sv
// Program-memory readback streamer: sends a count header byte, then each
// 32-bit word LSB-first over a byte-wide UART TX handshake.
module prog_mem_dump_fsm #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [BYTE_WIDTH-1:0] n_instructions,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  tx_ready,
    input  logic                  tx_done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  tx_start,
    output logic [BYTE_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        SEND_HDR  = 4'd1,
        WAIT_HDR  = 4'd2,
        RD_REQ    = 4'd3,
        RD_LATCH  = 4'd4,
        SEND_BYTE = 4'd5,
        WAIT_TX   = 4'd6,
        DONE      = 4'd7
    } state_t;

    state_t                  state_reg, state_next;
    logic [BYTE_WIDTH-1:0]   cnt_reg, cnt_next;
    logic [BYTE_WIDTH-1:0]   word_idx_reg, word_idx_next;
    logic [1:0]              byte_idx_reg, byte_idx_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   word_reg, word_next;
    logic [BYTE_WIDTH-1:0]   tx_data_reg, tx_data_next;
    logic                    tx_start_reg, tx_start_next;
    logic                    tx_done_ok;
    logic [BYTE_WIDTH-1:0]   word_bytes [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_split
            assign word_bytes[gi] = word_reg[gi*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    // tx_start is registered so the strobe lines up with the registered tx_data;
    // a tx_done seen in the launch cycle belongs to no byte of ours.
    assign tx_done_ok = tx_done && !tx_start_reg;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            word_idx_reg <= '0;
            byte_idx_reg <= '0;
            addr_reg     <= '0;
            word_reg     <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            word_idx_reg <= word_idx_next;
            byte_idx_reg <= byte_idx_next;
            addr_reg     <= addr_next;
            word_reg     <= word_next;
            tx_data_reg  <= tx_data_next;
            tx_start_reg <= tx_start_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        word_idx_next = word_idx_reg;
        byte_idx_next = byte_idx_reg;
        addr_next     = addr_reg;
        word_next     = word_reg;
        tx_data_next  = tx_data_reg;
        tx_start_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    cnt_next      = n_instructions;
                    word_idx_next = '0;
                    byte_idx_next = '0;
                    addr_next     = '0;
                    state_next    = SEND_HDR;
                end
            end
            SEND_HDR: begin
                if (tx_ready) begin
                    tx_start_next = 1'b1;
                    tx_data_next  = cnt_reg;
                    state_next    = WAIT_HDR;
                end
            end
            WAIT_HDR: begin
                if (tx_done_ok) begin
                    state_next = (cnt_reg == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                state_next = RD_LATCH;
            end
            RD_LATCH: begin
                word_next     = rd_data;
                byte_idx_next = '0;
                state_next    = SEND_BYTE;
            end
            SEND_BYTE: begin
                if (tx_ready) begin
                    tx_start_next = 1'b1;
                    tx_data_next  = word_bytes[byte_idx_reg];
                    state_next    = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (tx_done_ok) begin
                    if (byte_idx_reg != 2'd3) begin
                        byte_idx_next = byte_idx_reg + 2'd1;
                        state_next    = SEND_BYTE;
                    end else if (word_idx_reg == cnt_reg - BYTE_WIDTH'(1)) begin
                        state_next = DONE;
                    end else begin
                        word_idx_next = word_idx_reg + BYTE_WIDTH'(1);
                        addr_next     = addr_reg + ADDR_WIDTH'(4);
                        state_next    = RD_REQ;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rd_en    = (state_reg == RD_REQ);
    assign rd_addr  = addr_reg;
    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign state    = state_reg;

endmodule

// File: tb/tb_prog_mem_dump_fsm.sv
// Directed bench for prog_mem_dump_fsm: two instances (ADDR_WIDTH 10 and 4)
// driven by a simple UART TX model and a registered-read memory model.
module tb_prog_mem_dump_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             arst_n = 1'b0;
    logic [1:0]       start_v = '0;
    logic [1:0][7:0]  n_v = '0;
    logic [1:0][31:0] rd_data_v;
    logic [1:0]       tx_ready_v, tx_done_v, rd_en_v, tx_start_v, busy_v, done_v;
    logic [1:0][7:0]  tx_data_v;
    logic [1:0][3:0]  state_v;
    logic [1:0][9:0]  rd_addr_v;
    logic [9:0]       rd_addr0;
    logic [3:0]       rd_addr1;

    logic [1:0] uart_rdy  = 2'b11;
    logic [1:0] uart_done = 2'b00;
    logic [1:0] hold      = 2'b00;
    logic [1:0] inject    = 2'b00;
    int         ucnt [2] = '{default: 0};

    logic [7:0]  log_b [2][0:1023];
    logic [9:0]  log_a [2][0:63];
    int          nb [2] = '{default: 0};
    int          na [2] = '{default: 0};
    int          nd [2] = '{default: 0};
    int          viol [2] = '{default: 0};
    logic [31:0] mem [2][0:255];

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] expb [$];

    assign tx_ready_v = uart_rdy & ~hold;
    assign tx_done_v  = uart_done | inject;
    assign rd_addr_v  = {{6'd0, rd_addr1}, rd_addr0};

    prog_mem_dump_fsm #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10)) u_dut0 (
        .clk(clk), .arst_n(arst_n), .start(start_v[0]), .n_instructions(n_v[0]),
        .rd_data(rd_data_v[0]), .tx_ready(tx_ready_v[0]), .tx_done(tx_done_v[0]),
        .rd_en(rd_en_v[0]), .rd_addr(rd_addr0), .tx_start(tx_start_v[0]),
        .tx_data(tx_data_v[0]), .busy(busy_v[0]), .done(done_v[0]), .state(state_v[0])
    );

    prog_mem_dump_fsm #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) u_dut1 (
        .clk(clk), .arst_n(arst_n), .start(start_v[1]), .n_instructions(n_v[1]),
        .rd_data(rd_data_v[1]), .tx_ready(tx_ready_v[1]), .tx_done(tx_done_v[1]),
        .rd_en(rd_en_v[1]), .rd_addr(rd_addr1), .tx_start(tx_start_v[1]),
        .tx_data(tx_data_v[1]), .busy(busy_v[1]), .done(done_v[1]), .state(state_v[1])
    );

    // UART takes 4 cycles per byte; tx_done and tx_ready rise together.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            uart_done[i] <= 1'b0;
            if (tx_start_v[i]) begin
                if (!tx_ready_v[i]) viol[i] <= viol[i] + 1;
                log_b[i][nb[i]] <= tx_data_v[i];
                nb[i]           <= nb[i] + 1;
                uart_rdy[i]     <= 1'b0;
                ucnt[i]         <= 4;
            end else if (ucnt[i] > 0) begin
                ucnt[i] <= ucnt[i] - 1;
                if (ucnt[i] == 1) begin
                    uart_done[i] <= 1'b1;
                    uart_rdy[i]  <= 1'b1;
                end
            end
            if (rd_en_v[i]) begin
                log_a[i][na[i]] <= rd_addr_v[i];
                na[i]           <= na[i] + 1;
                rd_data_v[i]    <= mem[i][rd_addr_v[i][9:2]];
            end
            if (done_v[i]) nd[i] <= nd[i] + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic wait_state(input int i, input logic [3:0] s, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (state_v[i] == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_dump(input int i, input logic [7:0] n, input string tag);
        bit ok;
        @(negedge clk);
        start_v[i] = 1'b1;
        n_v[i]     = n;
        @(negedge clk);
        start_v[i] = 1'b0;
        wait_state(i, 4'd7, ok);
        check_eq({tag, " reached DONE"}, 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_seq(input string tag, input int i, input int base);
        check_eq({tag, " byte count"}, nb[i] - base, expb.size());
        for (int k = 0; k < expb.size(); k++)
            check_eq($sformatf("%s byte%0d", tag, k), 32'(log_b[i][base + k]), 32'(expb[k]));
    endtask

    task automatic check_idle(input int i, input string tag);
        check_eq({tag, " state"},    32'(state_v[i]),    32'd0);
        check_eq({tag, " busy"},     32'(busy_v[i]),     32'd0);
        check_eq({tag, " tx_start"}, 32'(tx_start_v[i]), 32'd0);
        check_eq({tag, " rd_en"},    32'(rd_en_v[i]),    32'd0);
        check_eq({tag, " done"},     32'(done_v[i]),     32'd0);
    endtask

    initial begin
        int  b0, a0, d0, stray, changed;
        bit  ok;
        logic [7:0] held;

        for (int w = 0; w < 256; w++) begin
            mem[0][w] = 32'h0;
            mem[1][w] = 32'h0;
        end
        mem[0][0] = 32'hDEADBEEF;
        mem[0][1] = 32'h01234567;
        for (int w = 0; w < 4; w++)
            mem[1][w] = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};

        // Reset state
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        check_idle(0, "reset");
        check_eq("reset tx_data", 32'(tx_data_v[0]), 32'd0);
        check_eq("reset rd_addr", 32'(rd_addr0), 32'd0);

        // Two-word dump with start-to-tx_start latency
        b0 = nb[0]; a0 = na[0]; d0 = nd[0];
        start_v[0] = 1'b1;
        n_v[0]     = 8'd2;
        @(negedge clk);
        start_v[0] = 1'b0;
        check_eq("t1 state after start", 32'(state_v[0]), 32'd1);
        check_eq("t1 tx_start at T+1", 32'(tx_start_v[0]), 32'd0);
        @(negedge clk);
        check_eq("t1 tx_start at T+2", 32'(tx_start_v[0]), 32'd1);
        check_eq("t1 busy", 32'(busy_v[0]), 32'd1);
        wait_state(0, 4'd7, ok);
        check_eq("t1 reached DONE", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        expb = {8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01};
        check_seq("t1", 0, b0);
        check_eq("t1 reads", na[0] - a0, 32'd2);
        check_eq("t1 addr0", 32'(log_a[0][a0]), 32'd0);
        check_eq("t1 addr1", 32'(log_a[0][a0 + 1]), 32'd4);
        check_eq("t1 done pulses", nd[0] - d0, 32'd1);
        check_idle(0, "t1 after");

        // Header-only dump
        b0 = nb[0]; a0 = na[0]; d0 = nd[0];
        run_dump(0, 8'd0, "t2");
        expb = {8'h00};
        check_seq("t2", 0, b0);
        check_eq("t2 reads", na[0] - a0, 32'd0);
        check_eq("t2 done pulses", nd[0] - d0, 32'd1);

        // Spurious tx_done outside the wait states and start re-pulsed mid-dump
        b0 = nb[0]; a0 = na[0]; d0 = nd[0];
        @(negedge clk);
        start_v[0] = 1'b1;
        n_v[0]     = 8'd2;
        @(negedge clk);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (state_v[0] == 4'd7) begin
                ok = 1'b1;
                break;
            end
            inject[0]  = (state_v[0] == 4'd1) || (state_v[0] == 4'd3) || (state_v[0] == 4'd4) ||
                         (((state_v[0] == 4'd2) || (state_v[0] == 4'd6)) && tx_start_v[0]);
            start_v[0] = (state_v[0] >= 4'd2) && (state_v[0] <= 4'd6);
            @(negedge clk);
        end
        inject[0]  = 1'b0;
        start_v[0] = 1'b0;
        check_eq("t4 reached DONE", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        expb = {8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01};
        check_seq("t4", 0, b0);
        check_eq("t4 reads", na[0] - a0, 32'd2);
        check_eq("t4 done pulses", nd[0] - d0, 32'd1);
        check_eq("t4 not restarted", 32'(state_v[0]), 32'd0);

        // tx_ready held low for 20 cycles in SEND_BYTE
        mem[0][0] = 32'hA5B6C7D8;
        b0 = nb[0];
        @(negedge clk);
        start_v[0] = 1'b1;
        n_v[0]     = 8'd1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_state(0, 4'd4, ok);
        check_eq("t3 reached RD_LATCH", 32'(ok), 32'd1);
        hold[0] = 1'b1;
        @(negedge clk);
        held = tx_data_v[0];
        stray = 0; changed = 0;
        for (int c = 0; c < 20; c++) begin
            if (tx_start_v[0]) stray++;
            if (tx_data_v[0] != held) changed++;
            @(negedge clk);
        end
        check_eq("t3 stalled state", 32'(state_v[0]), 32'd5);
        check_eq("t3 tx_start while stalled", stray, 32'd0);
        check_eq("t3 tx_data changes", changed, 32'd0);
        check_eq("t3 held tx_data", 32'(held), 32'h01);
        hold[0] = 1'b0;
        wait_state(0, 4'd7, ok);
        check_eq("t3 reached DONE", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        expb = {8'h01, 8'hD8, 8'hC7, 8'hB6, 8'hA5};
        check_seq("t3", 0, b0);

        // Reset during WAIT_TX of the second word, then a fresh one-word dump
        mem[0][0] = 32'hDEADBEEF;
        a0 = na[0];
        @(negedge clk);
        start_v[0] = 1'b1;
        n_v[0]     = 8'd2;
        @(negedge clk);
        start_v[0] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (state_v[0] == 4'd6 && (na[0] - a0) == 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("t5 reached word1 WAIT_TX", 32'(ok), 32'd1);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        check_idle(0, "t5 reset");
        check_eq("t5 reset tx_data", 32'(tx_data_v[0]), 32'd0);
        check_eq("t5 reset rd_addr", 32'(rd_addr0), 32'd0);
        b0 = nb[0]; a0 = na[0];
        repeat (10) @(negedge clk);
        check_eq("t5 no bytes after reset", nb[0] - b0, 32'd0);
        check_eq("t5 still idle", 32'(state_v[0]), 32'd0);
        run_dump(0, 8'd1, "t5b");
        expb = {8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        check_seq("t5b", 0, b0);
        check_eq("t5b reads", na[0] - a0, 32'd1);
        check_eq("t5b addr0", 32'(log_a[0][a0]), 32'd0);

        // Narrow address bus: read address wraps after 12
        b0 = nb[1]; a0 = na[1]; d0 = nd[1];
        run_dump(1, 8'd5, "t6");
        expb = {8'h05};
        for (int w = 0; w < 5; w++)
            for (int b = 0; b < 4; b++)
                expb.push_back(8'(4*(w % 4) + b));
        check_seq("t6", 1, b0);
        check_eq("t6 reads", na[1] - a0, 32'd5);
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("t6 addr%0d", k), 32'(log_a[1][a0 + k]), 32'(4*(k % 4)));
        check_eq("t6 done pulses", nd[1] - d0, 32'd1);

        check_eq("tx_start while not ready (dut0)", viol[0], 32'd0);
        check_eq("tx_start while not ready (dut1)", viol[1], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
